// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller FSM: lookup, write hit, write-through,
// dirty eviction burst, line fill burst, tag update, with a RAM timeout watchdog.
module cache_ctrl_nway #(
  parameter int WAYS        = 4,
  parameter int LINE_WORDS  = 4,
  parameter int WRITE_BACK  = 1,
  parameter int RAM_TIMEOUT = 255,
  localparam int WAY_W      = $clog2(WAYS),
  localparam int WORD_W     = $clog2(LINE_WORDS),
  localparam int TMO_W      = $clog2(RAM_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic              sys_rd,
  input  logic              sys_wr,
  input  logic [WAYS-1:0]   hit_vec,
  input  logic              victim_dirty,
  input  logic              ram_ack,
  output logic              ram_avalid,
  output logic              ram_rnw,
  output logic [WORD_W-1:0] ram_word_idx,
  output logic [WAY_W-1:0]  way_sel,
  output logic [WAY_W-1:0]  victim_way,
  output logic              data_we,
  output logic              data_sel,
  output logic              tag_we,
  output logic              dirty_set,
  output logic              dirty_clr,
  output logic              sys_ack,
  output logic              sys_err,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WHIT, S_WTHRU, S_EVICT, S_FILL, S_UPDATE, S_ACK, S_ERR
  } state_e;

  localparam logic [WORD_W-1:0] CNT_LAST = WORD_W'(LINE_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(RAM_TIMEOUT - 1);

  state_e              state_q;
  logic [WAY_W-1:0]    victim_q;
  logic [WAY_W-1:0]    way_q;
  logic [WORD_W-1:0]   cnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                wr_q;
  logic [WAY_W-1:0]    hit_idx;
  logic                hit_any;

  // Lowest-index matching way wins when several tags match.
  always_comb begin
    hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = WAY_W'(i);
    end
  end

  assign hit_any    = |hit_vec;
  assign victim_way = victim_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      way_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sys_rd ^ sys_wr) begin
            wr_q    <= sys_wr;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          cnt_q <= '0;
          tmo_q <= '0;
          if (hit_any) begin
            way_q   <= hit_idx;
            state_q <= wr_q ? S_WHIT : S_ACK;
          end else if ((WRITE_BACK != 0) && victim_dirty) begin
            state_q <= S_EVICT;
          end else begin
            state_q <= S_FILL;
          end
        end
        S_WHIT: begin
          tmo_q   <= '0;
          state_q <= (WRITE_BACK != 0) ? S_ACK : S_WTHRU;
        end
        // Watchdog restarts on every accepted beat, so it bounds each beat, not the burst.
        S_WTHRU, S_EVICT, S_FILL: begin
          if (ram_ack) begin
            tmo_q <= '0;
            if (state_q == S_WTHRU) begin
              state_q <= S_ACK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CNT_LAST) state_q <= (state_q == S_EVICT) ? S_FILL : S_UPDATE;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_UPDATE: begin
          victim_q <= victim_q + 1'b1;
          state_q  <= S_LOOKUP;
        end
        S_ACK, S_ERR: begin
          if (!sys_rd && !sys_wr) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_avalid   = 1'b0;
    ram_rnw      = 1'b1;
    ram_word_idx = '0;
    way_sel      = way_q;
    data_we      = 1'b0;
    data_sel     = 1'b0;
    tag_we       = 1'b0;
    dirty_set    = 1'b0;
    dirty_clr    = 1'b0;
    sys_ack      = 1'b0;
    sys_err      = 1'b0;
    case (state_q)
      S_LOOKUP: way_sel = hit_idx;
      S_WHIT: begin
        data_we   = 1'b1;
        dirty_set = (WRITE_BACK != 0);
      end
      S_WTHRU: begin
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
      end
      S_EVICT: begin
        ram_avalid   = 1'b1;
        ram_rnw      = 1'b0;
        way_sel      = victim_q;
        ram_word_idx = cnt_q;
      end
      S_FILL: begin
        ram_avalid   = 1'b1;
        way_sel      = victim_q;
        ram_word_idx = cnt_q;
        data_sel     = 1'b1;
        data_we      = ram_ack;
      end
      S_UPDATE: begin
        tag_we    = 1'b1;
        dirty_clr = 1'b1;
        way_sel   = victim_q;
      end
      S_ACK: sys_ack = 1'b1;
      S_ERR: begin
        sys_ack = 1'b1;
        sys_err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway: a write-back instance (index 0) and a write-through instance
// (index 1), driven by randomized requests and checked against a transaction-level model.
module tb_cache_ctrl_nway;

  localparam int LW     = 4;
  localparam int NWAYS  = 4;
  localparam int TMO_WB = 8;
  localparam logic [14:0] RST_OUTS = 15'h2000;  // only ram_rnw high

  logic       clk;
  logic       not_reset;
  logic [1:0] sys_rd, sys_wr, victim_dirty, ram_ack;
  logic [3:0] hit_vec [2];
  logic [1:0] ram_avalid, ram_rnw, data_we, data_sel, tag_we, dirty_set, dirty_clr, sys_ack, sys_err;
  logic [1:0] ram_word_idx [2];
  logic [1:0] way_sel [2];
  logic [1:0] victim_way [2];
  logic [3:0] dbg_state [2];

  int checks = 0;
  int failures = 0;
  int exp_victim [2];

  // Per-request observation log
  logic [4:0] beat_q[$];
  logic [4:0] exp_q[$];
  int n_fill_we, n_sys_we, n_dset, n_dclr, n_tag, run_max, lat;
  logic [1:0] tag_way, sys_we_way, ack_way;
  bit got_ack, got_err;

  cache_ctrl_nway #(.WAYS(NWAYS), .LINE_WORDS(LW), .WRITE_BACK(1), .RAM_TIMEOUT(TMO_WB)) dut_wb (
    .clk(clk), .not_reset(not_reset), .sys_rd(sys_rd[0]), .sys_wr(sys_wr[0]),
    .hit_vec(hit_vec[0]), .victim_dirty(victim_dirty[0]), .ram_ack(ram_ack[0]),
    .ram_avalid(ram_avalid[0]), .ram_rnw(ram_rnw[0]), .ram_word_idx(ram_word_idx[0]),
    .way_sel(way_sel[0]), .victim_way(victim_way[0]), .data_we(data_we[0]), .data_sel(data_sel[0]),
    .tag_we(tag_we[0]), .dirty_set(dirty_set[0]), .dirty_clr(dirty_clr[0]),
    .sys_ack(sys_ack[0]), .sys_err(sys_err[0]), .dbg_state(dbg_state[0])
  );

  cache_ctrl_nway #(.WAYS(NWAYS), .LINE_WORDS(LW), .WRITE_BACK(0), .RAM_TIMEOUT(16)) dut_wt (
    .clk(clk), .not_reset(not_reset), .sys_rd(sys_rd[1]), .sys_wr(sys_wr[1]),
    .hit_vec(hit_vec[1]), .victim_dirty(victim_dirty[1]), .ram_ack(ram_ack[1]),
    .ram_avalid(ram_avalid[1]), .ram_rnw(ram_rnw[1]), .ram_word_idx(ram_word_idx[1]),
    .way_sel(way_sel[1]), .victim_way(victim_way[1]), .data_we(data_we[1]), .data_sel(data_sel[1]),
    .tag_we(tag_we[1]), .dirty_set(dirty_set[1]), .dirty_clr(dirty_clr[1]),
    .sys_ack(sys_ack[1]), .sys_err(sys_err[1]), .dbg_state(dbg_state[1])
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] outs(input int d);
    return {ram_avalid[d], ram_rnw[d], ram_word_idx[d], way_sel[d], victim_way[d], data_we[d],
            data_sel[d], tag_we[d], dirty_set[d], dirty_clr[d], sys_ack[d], sys_err[d]};
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] hv);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (hv[i]) r = 2'(i);
    return r;
  endfunction

  // Driver: issue one request, act as RAM, log what the controller does until sys_ack.
  task automatic run_req(input int d, input bit wr, input logic [3:0] hv, input bit dirty,
                         input int ack_mode);
    int wait_left, run, acks, cyc;
    beat_q.delete();
    n_fill_we = 0; n_sys_we = 0; n_dset = 0; n_dclr = 0; n_tag = 0; run_max = 0; lat = -1;
    got_ack = 0; got_err = 0; run = 0; acks = 0; cyc = 0;
    wait_left = $urandom_range(0, 3);
    @(negedge clk);
    hit_vec[d] = hv;
    victim_dirty[d] = dirty;
    if (wr) sys_wr[d] = 1'b1; else sys_rd[d] = 1'b1;
    while (cyc < 200 && !got_ack) begin
      @(negedge clk);
      cyc++;
      ram_ack[d] = 1'b0;
      if (ram_avalid[d]) begin
        if (ack_mode == 1) begin
          if (wait_left == 0) begin ram_ack[d] = 1'b1; wait_left = $urandom_range(0, 3); end
          else wait_left--;
        end else if (ack_mode == 2 && acks == 0) begin
          ram_ack[d] = 1'b1;
        end
      end
      #1;
      if (ram_avalid[d]) begin
        if (ram_ack[d]) begin
          beat_q.push_back({ram_rnw[d], way_sel[d], ram_word_idx[d]});
          acks++;
          run = 0;
        end else begin
          run++;
          if (run > run_max) run_max = run;
        end
      end
      if (data_we[d] && data_sel[d]) n_fill_we++;
      if (data_we[d] && !data_sel[d]) begin n_sys_we++; sys_we_way = way_sel[d]; end
      if (dirty_set[d]) n_dset++;
      if (dirty_clr[d]) n_dclr++;
      if (tag_we[d]) begin
        n_tag++;
        tag_way = way_sel[d];
        hit_vec[d] = 4'b0001 << way_sel[d];
      end
      if (sys_ack[d]) begin
        got_ack = 1; got_err = sys_err[d]; lat = cyc; ack_way = way_sel[d];
      end
    end
    ram_ack[d] = 1'b0;
    checks++;
    if (!got_ack) begin
      failures++;
      $display("FAIL req_budget dut%0d: sys_ack=0 after %0d cycles, required 1", d, cyc);
    end
  endtask

  // Hold the request past sys_ack, then drop it and expect a return to idle.
  task automatic finish_req(input int d, input string name);
    int n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      checks++;
      if (sys_ack[d] !== 1'b1) begin
        failures++;
        $display("FAIL %s ack_hold dut%0d: sys_ack=%b required 1", name, d, sys_ack[d]);
      end
    end
    @(negedge clk);
    sys_rd[d] = 1'b0;
    sys_wr[d] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (sys_ack[d] !== 1'b0 || ram_avalid[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s release dut%0d: sys_ack=%b ram_avalid=%b required 0 0", name, d,
               sys_ack[d], ram_avalid[d]);
    end
    checks++;
    if (victim_way[d] !== 2'(exp_victim[d])) begin
      failures++;
      $display("FAIL %s victim dut%0d: got %0d required %0d", name, d, victim_way[d], exp_victim[d]);
    end
  endtask

  // Reference model: what a request must produce, from the protocol rules.
  task automatic do_req(input int d, input bit wr, input logic [3:0] hv, input bit dirty,
                        input string name);
    bit wb = (d == 0);
    bit hit = (hv != 4'b0);
    logic [1:0] hway = lowest(hv);
    logic [1:0] vic = 2'(exp_victim[d]);
    int exp_fill = 0;
    int exp_tag = 0;
    exp_q.delete();
    if (!hit) begin
      if (wb && dirty) for (int i = 0; i < LW; i++) exp_q.push_back({1'b0, vic, 2'(i)});
      for (int i = 0; i < LW; i++) exp_q.push_back({1'b1, vic, 2'(i)});
      exp_fill = LW;
      exp_tag = 1;
      hway = vic;
      exp_victim[d] = (exp_victim[d] + 1) % NWAYS;
    end
    if (wr && !wb) exp_q.push_back({1'b0, hway, 2'd0});
    run_req(d, wr, hv, dirty, 1);
    checks++;
    if (got_err !== 1'b0) begin
      failures++; $display("FAIL %s sys_err: got %b required 0", name, got_err);
    end
    checks++;
    if (beat_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s beat_count: got %0d required %0d", name, beat_q.size(), exp_q.size());
    end
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (beat_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s beat%0d {rnw,way,idx}: got %b required %b", name, i, beat_q[i], exp_q[i]);
      end
    end
    checks++;
    if (n_fill_we != exp_fill || n_tag != exp_tag || n_dclr != exp_tag) begin
      failures++;
      $display("FAIL %s fill/tag: fill_we=%0d tag_we=%0d dirty_clr=%0d required %0d %0d %0d",
               name, n_fill_we, n_tag, n_dclr, exp_fill, exp_tag, exp_tag);
    end
    checks++;
    if (n_sys_we != int'(wr) || n_dset != int'(wr && wb)) begin
      failures++;
      $display("FAIL %s sys_write: data_we=%0d dirty_set=%0d required %0d %0d", name, n_sys_we,
               n_dset, int'(wr), int'(wr && wb));
    end
    if (exp_tag != 0) begin
      checks++;
      if (tag_way !== vic) begin
        failures++; $display("FAIL %s tag_way: got %0d required %0d", name, tag_way, vic);
      end
    end
    if (wr) begin
      checks++;
      if (sys_we_way !== hway) begin
        failures++; $display("FAIL %s write_way: got %0d required %0d", name, sys_we_way, hway);
      end
    end
    checks++;
    if (ack_way !== hway) begin
      failures++; $display("FAIL %s ack_way: got %0d required %0d", name, ack_way, hway);
    end
    finish_req(d, name);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== RST_OUTS) begin
        failures++; $display("FAIL reset_outs dut%0d: got %h required %h", d, outs(d), RST_OUTS);
      end
    end
  endtask

  task automatic test_read_hit();
    do_req(0, 1'b0, 4'b0100, 1'b0, "read_hit");
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL read_hit_latency: got %0d required 2", lat);
    end
  endtask

  task automatic test_misses();
    do_req(0, 1'b0, 4'b0000, 1'b0, "clean_miss");
    do_req(0, 1'b0, 4'b0000, 1'b1, "dirty_read_miss");
    do_req(0, 1'b1, 4'b0000, 1'b1, "dirty_write_miss");
    do_req(0, 1'b1, 4'b1000, 1'b0, "wb_write_hit");
  endtask

  task automatic test_write_through();
    do_req(1, 1'b1, 4'b0010, 1'b0, "wt_write_hit");
    do_req(1, 1'b1, 4'b0000, 1'b1, "wt_write_miss");
    do_req(1, 1'b0, 4'b0000, 1'b1, "wt_read_miss");
  endtask

  task automatic test_timeout();
    logic [1:0] vic = 2'(exp_victim[0]);
    for (int m = 0; m < 2; m++) begin
      // mode 0: no ack at all during a fill; mode 2: one evict beat then silence
      run_req(0, 1'b0, 4'b0000, (m == 1), (m == 0) ? 0 : 2);
      checks++;
      if (got_err !== 1'b1 || run_max != TMO_WB) begin
        failures++;
        $display("FAIL timeout%0d: sys_err=%b wait_cycles=%0d required 1 %0d", m, got_err, run_max, TMO_WB);
      end
      checks++;
      if (beat_q.size() != m || n_tag != 0) begin
        failures++;
        $display("FAIL timeout%0d beats/tag: got %0d %0d required %0d 0", m, beat_q.size(), n_tag, m);
      end
      if (m == 1 && beat_q.size() == 1) begin
        checks++;
        if (beat_q[0] !== {1'b0, vic, 2'd0}) begin
          failures++; $display("FAIL timeout_beat: got %b required %b", beat_q[0], {1'b0, vic, 2'd0});
        end
      end
      finish_req(0, "timeout");
    end
  endtask

  task automatic test_illegal_both();
    @(negedge clk);
    sys_rd[0] = 1'b1;
    sys_wr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({ram_avalid[0], sys_ack[0], tag_we[0], data_we[0]} !== 4'b0) begin
        failures++;
        $display("FAIL illegal_both: avalid/ack/tag_we/data_we=%b required 0000",
                 {ram_avalid[0], sys_ack[0], tag_we[0], data_we[0]});
      end
    end
    sys_rd[0] = 1'b0;
    sys_wr[0] = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int d = $urandom_range(0, 1);
      logic [3:0] hv = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      do_req(d, 1'($urandom_range(0, 1)), hv, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_fill();
    int acks = 0;
    int cyc = 0;
    @(negedge clk);
    hit_vec[0] = 4'b0;
    victim_dirty[0] = 1'b0;
    sys_rd[0] = 1'b1;
    while (acks < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      ram_ack[0] = ram_avalid[0];
      #1;
      if (ram_ack[0]) acks++;
    end
    checks++;
    if (acks < 2) begin
      failures++; $display("FAIL reset_mid_fill_start: beats=%0d required 2", acks);
    end
    @(negedge clk);
    ram_ack[0] = 1'b0;
    not_reset = 1'b0;
    #1;
    exp_victim[0] = 0;
    exp_victim[1] = 0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== RST_OUTS) begin
        failures++; $display("FAIL reset_mid_fill dut%0d: got %h required %h", d, outs(d), RST_OUTS);
      end
    end
    sys_rd[0] = 1'b0;
    @(negedge clk);
    not_reset = 1'b1;
  endtask

  task automatic test_victim_wrap();
    for (int i = 0; i < 5; i++) do_req(0, 1'b0, 4'b0000, 1'b0, "victim_wrap");
  endtask

  initial begin
    not_reset = 1'b0;
    sys_rd = '0; sys_wr = '0; victim_dirty = '0; ram_ack = '0;
    hit_vec[0] = '0; hit_vec[1] = '0;
    exp_victim[0] = 0; exp_victim[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    not_reset = 1'b1;
    test_read_hit();
    test_misses();
    test_write_through();
    test_timeout();
    test_illegal_both();
    test_random();
    test_reset_mid_fill();
    test_victim_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
